// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by both async-FIFO clock domains: Gray/binary
// conversion and modulo pointer difference, sized for the widest pointer.
package fifo_ptr_pkg;

  localparam int MAX_PTR_W = 16;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits do not disturb the XOR prefix, so narrow pointers
  // can be widened, converted and truncated back.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t occ_diff(input ptr_t a, input ptr_t b, input int w);
    ptr_t mask;
    mask = (ptr_t'(1) << w) - ptr_t'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/sync_bus_nff.sv
// Generic WIDTH x STAGES synchroniser chain with async active-low reset.
// Used for both pointer crossing directions of the async FIFO.
module sync_bus_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sync_w2r_cnt.sv
// Write-pointer to read-domain synchroniser with registered Gray decode,
// occupancy count and non-empty flag. Define SYNC_W2R_CHK_EN for the checker.
module sync_w2r_cnt
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  input  logic [ADDRSIZE:0] rptr_bin,
  input  logic              clr_err,
  output logic [ADDRSIZE:0] rq_wptr_gray,
  output logic [ADDRSIZE:0] rq_wptr_bin,
  output logic [ADDRSIZE:0] rcount,
  output logic              rnonempty,
  output logic              rovf_err
);

  localparam int   PTR_W    = ptr_width(ADDRSIZE);
  localparam ptr_t FULL_CNT = ptr_t'(1) << ADDRSIZE;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_w2r_cnt: SYNC_STAGES must be 2..4");
  end
  if (PTR_W > MAX_PTR_W) begin : g_bad_addr
    $error("sync_w2r_cnt: ADDRSIZE too large for fifo_ptr_pkg");
  end

  logic [PTR_W-1:0] gray_sync;
  logic [PTR_W-1:0] rq_bin_q, rq_bin_d;
  logic [PTR_W-1:0] rcount_q, rcount_d;
  logic             nonempty_q, nonempty_d;

  sync_bus_nff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .d_i    (wptr),
    .q_o    (gray_sync)
  );

  always_comb begin
    rq_bin_d   = PTR_W'(gray2bin(ptr_t'(gray_sync)));
    rcount_d   = PTR_W'(occ_diff(ptr_t'(rq_bin_q), ptr_t'(rptr_bin), PTR_W));
    nonempty_d = (rq_bin_q != rptr_bin);
  end

  // Decode stage then occupancy stage, each one rclk edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq_bin_q   <= '0;
      rcount_q   <= '0;
      nonempty_q <= 1'b0;
    end else begin
      rq_bin_q   <= rq_bin_d;
      rcount_q   <= rcount_d;
      nonempty_q <= nonempty_d;
    end
  end

  assign rq_wptr_gray = gray_sync;
  assign rq_wptr_bin  = rq_bin_q;
  assign rcount       = rcount_q;
  assign rnonempty    = nonempty_q;

`ifdef SYNC_W2R_CHK_EN
  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  logic [2:0]       settle_q, settle_d;
  logic [PTR_W-1:0] prev_bin_q;
  logic             err_q, err_d;
  logic             chk_active, ovf_hit, bwd_hit;

  // Hold off until the chain has flushed the reset zeros.
  always_comb begin
    settle_d   = settle_q;
    chk_active = (settle_q == SETTLE_DONE);
    if (!chk_active) settle_d = settle_q + 3'd1;
    ovf_hit = occ_diff(ptr_t'(rq_bin_q), ptr_t'(rptr_bin), PTR_W) > FULL_CNT;
    bwd_hit = occ_diff(ptr_t'(rq_bin_q), ptr_t'(prev_bin_q), PTR_W) > FULL_CNT;
    err_d   = err_q;
    if (chk_active && (ovf_hit || bwd_hit)) err_d = 1'b1;
    else if (clr_err)                       err_d = 1'b0;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      settle_q   <= '0;
      prev_bin_q <= '0;
      err_q      <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      prev_bin_q <= rq_bin_q;
      err_q      <= err_d;
    end
  end

  assign rovf_err = err_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign rovf_err       = 1'b0;
`endif

endmodule

// File: tb/tb_sync_w2r_cnt.sv
// Bench for sync_w2r_cnt: SYNC_STAGES=2 and =3 instances on shared stimulus,
// checked against a cycle-history reference model.
module tb_sync_w2r_cnt;

`ifdef SYNC_W2R_CHK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [4:0] wptr = '0;
  logic [4:0] rptr_bin = '0;
  logic       clr_err = 1'b0;

  logic [4:0] g2, b2, c2, g3, b3, c3;
  logic       ne2, e2, ne3, e3;

  int checks = 0;
  int errors = 0;

  // Model history: index k holds inputs sampled at edge k after reset release.
  int win [0:4095];
  int rin [0:4095];
  bit cl  [0:4095];
  int n = 0;
  bit merr2 = 1'b0;
  bit merr3 = 1'b0;

  always #5 rclk = ~rclk;

  sync_w2r_cnt #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rptr_bin(rptr_bin), .clr_err(clr_err),
    .rq_wptr_gray(g2), .rq_wptr_bin(b2), .rcount(c2), .rnonempty(ne2), .rovf_err(e2));

  sync_w2r_cnt #(.ADDRSIZE(4), .SYNC_STAGES(3)) dut3 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rptr_bin(rptr_bin), .clr_err(clr_err),
    .rq_wptr_gray(g3), .rq_wptr_bin(b3), .rcount(c3), .rnonempty(ne3), .rovf_err(e3));

  function automatic int mbin(input int s, input int k);
    if (k - s >= 1) return win[k-s];
    return 0;
  endfunction

  function automatic int mgray(input int s, input int k);
    int b;
    b = (k - s + 1 >= 1) ? win[k-s+1] : 0;
    return b ^ (b >> 1);
  endfunction

  function automatic int mcnt(input int s, input int k);
    if (k < 1) return 0;
    return (mbin(s, k-1) - rin[k]) & 31;
  endfunction

  function automatic bit mne(input int s, input int k);
    if (k < 1) return 1'b0;
    return mbin(s, k-1) != rin[k];
  endfunction

  function automatic bit mnext_err(input int s, input bit cur);
    bit set;
    set = CHK_ON && (n - 1 >= s + 1) &&
          ((((mbin(s, n-1) - rin[n]) & 31) > 16) ||
           (((mbin(s, n-1) - mbin(s, n-2)) & 31) > 16));
    if (set) return 1'b1;
    if (CHK_ON && cl[n]) return 1'b0;
    return CHK_ON ? cur : 1'b0;
  endfunction

  function automatic logic [16:0] mexp(input int s);
    return {5'(mgray(s, n)), 5'(mbin(s, n)), 5'(mcnt(s, n)), mne(s, n),
            (s == 2) ? merr2 : merr3};
  endfunction

  task automatic tick(input int wb, input int rb, input bit c);
    wptr     = 5'((wb & 31) ^ ((wb & 31) >> 1));
    rptr_bin = 5'(rb & 31);
    clr_err  = c;
    win[n+1] = wb & 31;
    rin[n+1] = rb & 31;
    cl[n+1]  = c;
    @(posedge rclk);
    n++;
    merr2 = mnext_err(2, merr2);
    merr3 = mnext_err(3, merr3);
    #1;
  endtask

  task automatic test_reset;
    rrst_n = 1'b0; wptr = 5'h1B; rptr_bin = '0; clr_err = 1'b0;
    n = 0; merr2 = 1'b0; merr3 = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    checks++;
    if ({g2, b2, c2, ne2, e2} !== 17'h0) begin
      errors++; $display("FAIL reset_dut2 got %h want 0", {g2, b2, c2, ne2, e2});
    end
    checks++;
    if ({g3, b3, c3, ne3, e3} !== 17'h0) begin
      errors++; $display("FAIL reset_dut3 got %h want 0", {g3, b3, c3, ne3, e3});
    end
    rrst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(2, 0, 1'b0);
      checks++;
      if ({g2, b2, c2, ne2, e2} !== mexp(2)) begin
        errors++; $display("FAIL reset_seq_dut2 got %h want %h", {g2, b2, c2, ne2, e2}, mexp(2));
      end
      if (i == 1) begin
        checks++;
        if (g2 !== 5'b00000) begin errors++; $display("FAIL gray_early got %b want 00000", g2); end
      end
      if (i == 2) begin
        checks++;
        if (g2 !== 5'b00011) begin errors++; $display("FAIL gray_lat got %b want 00011", g2); end
      end
      if (i == 3) begin
        checks++;
        if (b2 !== 5'd2) begin errors++; $display("FAIL bin_lat got %0d want 2", b2); end
      end
      if (i == 4) begin
        checks++;
        if ({c2, ne2} !== {5'd2, 1'b1}) begin
          errors++; $display("FAIL count_lat got %0d/%0d want 2/1", c2, ne2);
        end
      end
    end
  endtask

  task automatic test_wrap;
    for (int wb = 3; wb <= 28; wb++) begin
      tick(wb, (wb > 6) ? wb - 6 : 0, 1'b0);
      checks++;
      if ({g3, b3, c3, ne3, e3} !== mexp(3)) begin
        errors++; $display("FAIL ramp_dut3 got %h want %h", {g3, b3, c3, ne3, e3}, mexp(3));
      end
    end
    repeat (6) tick(28, 22, 1'b0);
    repeat (2) tick(28, 28, 1'b0);
    tick(30, 28, 1'b0);
    tick(31, 28, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 28, 1'b0);
      checks++;
      if ({g2, b2, c2, ne2, e2} !== mexp(2)) begin
        errors++; $display("FAIL wrap_dut2 got %h want %h", {g2, b2, c2, ne2, e2}, mexp(2));
      end
    end
    checks++;
    if ({c2, e2} !== {5'd4, 1'b0}) begin
      errors++; $display("FAIL wrap_final got count %0d err %0d want 4/0", c2, e2);
    end
  endtask

  task automatic test_full_ovf;
    repeat (6) tick(0, 0, 1'b0);
    repeat (6) tick(16, 0, 1'b0);
    checks++;
    if ({c2, ne2, e2} !== {5'd16, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full got count %0d ne %0d err %0d want 16/1/0", c2, ne2, e2);
    end
    tick(17, 0, 1'b0); tick(17, 0, 1'b0); tick(17, 0, 1'b0);
    checks++;
    if ({b2, e2} !== {5'd17, 1'b0}) begin
      errors++; $display("FAIL ovf_pre got bin %0d err %0d want 17/0", b2, e2);
    end
    tick(17, 0, 1'b0);
    checks++;
    if ({c2, e2} !== {5'd17, CHK_ON}) begin
      errors++; $display("FAIL ovf_set got count %0d err %0d want 17/%0d", c2, e2, CHK_ON);
    end
    for (int i = 0; i < 5; i++) begin
      tick(16, 0, 1'b0);
      checks++;
      if ({g2, b2, c2, ne2, e2} !== mexp(2)) begin
        errors++; $display("FAIL ovf_hold_dut2 got %h want %h", {g2, b2, c2, ne2, e2}, mexp(2));
      end
    end
    checks++;
    if (e2 !== CHK_ON) begin errors++; $display("FAIL ovf_sticky got %0d want %0d", e2, CHK_ON); end
    tick(16, 0, 1'b1);
    checks++;
    if ({e2, e3} !== 2'b00) begin
      errors++; $display("FAIL ovf_clear got %0d%0d want 00", e2, e3);
    end
  endtask

  task automatic test_backward_clear;
    repeat (6) tick(10, 0, 1'b0);
    repeat (6) tick(8, 0, 1'b0);
    checks++;
    if ({e2, e3} !== {CHK_ON, CHK_ON}) begin
      errors++; $display("FAIL bwd_set got %0d%0d want %0d%0d", e2, e3, CHK_ON, CHK_ON);
    end
    tick(8, 20, 1'b1);
    checks++;
    if (e2 !== CHK_ON) begin errors++; $display("FAIL set_wins got %0d want %0d", e2, CHK_ON); end
    repeat (3) tick(8, 0, 1'b0);
    tick(8, 0, 1'b1);
    checks++;
    if ({g2, b2, c2, ne2, e2} !== mexp(2) || e2 !== 1'b0) begin
      errors++; $display("FAIL bwd_clear got %h want %h", {g2, b2, c2, ne2, e2}, mexp(2));
    end
  endtask

  task automatic test_random;
    int wb, rb, avail, step;
    bit c;
    wb = 8; rb = 0;
    for (int i = 0; i < 300; i++) begin
      step = int'($urandom_range(0, 3));
      if (((wb + step - rb) & 31) <= 16) wb = (wb + step) & 31;
      avail = (mbin(3, n) - rb) & 31;
      step = int'($urandom_range(0, 3));
      if (step > avail) step = avail;
      rb = (rb + step) & 31;
      c = ($urandom_range(0, 15) == 0);
      tick(wb, rb, c);
      checks++;
      if ({g2, b2, c2, ne2, e2} !== mexp(2)) begin
        errors++; $display("FAIL rand_dut2 cyc %0d got %h want %h", i, {g2, b2, c2, ne2, e2}, mexp(2));
      end
      checks++;
      if ({g3, b3, c3, ne3, e3} !== mexp(3)) begin
        errors++; $display("FAIL rand_dut3 cyc %0d got %h want %h", i, {g3, b3, c3, ne3, e3}, mexp(3));
      end
    end
    repeat (6) tick(wb, rb, 1'b0);
    repeat (2) tick(wb, wb, 1'b0);
  endtask

  task automatic test_stages3;
    int w0;
    logic [4:0] gnew;
    w0 = win[n];
    gnew = 5'(((w0 + 1) & 31) ^ (((w0 + 1) & 31) >> 1));
    for (int i = 1; i <= 5; i++) begin
      tick(w0 + 1, w0, 1'b0);
      if (i == 2) begin
        checks++;
        if (g3 === gnew) begin errors++; $display("FAIL s3_gray_early got %b changed at edge 2", g3); end
      end
      if (i == 3) begin
        checks++;
        if (g3 !== gnew) begin errors++; $display("FAIL s3_gray_lat got %b want %b", g3, gnew); end
      end
      if (i == 4) begin
        checks++;
        if (c3 !== 5'd0) begin errors++; $display("FAIL s3_cnt_early got %0d want 0", c3); end
      end
      if (i == 5) begin
        checks++;
        if (c3 !== 5'd1) begin errors++; $display("FAIL s3_cnt_lat got %0d want 1", c3); end
      end
    end
    #3;
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({g2, b2, c2, ne2, e2, g3, b3, c3, ne3, e3} !== 34'h0) begin
      errors++; $display("FAIL async_rst got %h %h want 0", {g2, b2, c2, ne2, e2}, {g3, b3, c3, ne3, e3});
    end
    n = 0; merr2 = 1'b0; merr3 = 1'b0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(3, 1, 1'b0);
      checks++;
      if ({g3, b3, c3, ne3, e3} !== mexp(3)) begin
        errors++; $display("FAIL post_rst_dut3 got %h want %h", {g3, b3, c3, ne3, e3}, mexp(3));
      end
    end
    checks++;
    if ({c3, e3, c2, e2} !== {5'd2, 1'b0, 5'd2, 1'b0}) begin
      errors++; $display("FAIL post_rst_final got %0d/%0d %0d/%0d want 2/0 2/0", c3, e3, c2, e2);
    end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_full_ovf;
    test_backward_clear;
    test_random;
    test_stages3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
